uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 144 ++++++++++++++
 tb/tb_uart_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit, then a one-clock done pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int   CLKS_PER_BIT = 1085,
    parameter int   DATA_WIDTH   = 8,
    parameter logic START_BIT    = 1'b0,
    parameter logic STOP_BIT     = 1'b1
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  i_tx,
    input  logic [DATA_WIDTH-1:0] i_tx_byte,
    output logic                  o_tx_serial,
    output logic                  o_tx_d
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
`endif

    state_t                  state_reg,  state_next;
    logic [CNT_W-1:0]        cnt_reg,    cnt_next;
    logic [BIT_W-1:0]        bit_reg,    bit_next;
    logic [DATA_WIDTH-1:0]   shift_reg,  shift_next;
    logic                    serial_reg, serial_next;
    logic                    done_reg,   done_next;
    logic                    bit_end;
`ifdef UART_TX_PARITY_EN
    logic                    parity_reg, parity_next;
`endif

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            serial_reg <= STOP_BIT;
            done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            serial_reg <= serial_next;
            done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // The counter is reset on entry to each bit, so CNT_LAST marks the final clock of that bit.
    assign bit_end = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        serial_next = serial_reg;
        done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        if (state_reg != IDLE && state_reg != DONE) begin
            cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
        end
        case (state_reg)
            IDLE: begin
                serial_next = STOP_BIT;
                if (i_tx) begin
                    shift_next  = i_tx_byte;
                    serial_next = START_BIT;
                    cnt_next    = '0;
                    bit_next    = '0;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^i_tx_byte;
`endif
                    state_next  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    serial_next = shift_reg[0];
                    state_next  = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        serial_next = parity_reg;
                        state_next  = PARITY;
`else
                        serial_next = STOP_BIT;
                        state_next  = STOP;
`endif
                    end else begin
                        bit_next    = bit_reg + 1'b1;
                        shift_next  = shift_reg >> 1;
                        serial_next = shift_next[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    serial_next = STOP_BIT;
                    state_next  = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                serial_next = STOP_BIT;
                state_next  = IDLE;
            end
            default: begin
                serial_next = STOP_BIT;
                state_next  = IDLE;
            end
        endcase
    end

    assign o_tx_serial = serial_reg;
    assign o_tx_d      = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: requested bytes are queued and a line monitor decodes each frame mid-bit.
module tb_uart_tx;
    localparam int CPB = 8;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          sysclk = 1'b0;
    logic          rst = 1'b1;
    logic          i_tx = 1'b0;
    logic [DW-1:0] i_tx_byte = '0;
    logic          o_tx_serial;
    logic          o_tx_d;

    int            errors = 0;
    int            checks = 0;
    int            frames = 0;
    int            done_cnt = 0;
    bit            mon_en = 1'b0;
    bit            mon_busy = 1'b0;
    logic [DW-1:0] sb[$];

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .START_BIT(1'b0), .STOP_BIT(1'b1)) dut (
        .sysclk(sysclk), .rst(rst), .i_tx(i_tx), .i_tx_byte(i_tx_byte),
        .o_tx_serial(o_tx_serial), .o_tx_d(o_tx_d)
    );

    always #4 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge sysclk) begin
        if (o_tx_d === 1'b1) done_cnt++;
    end

    // Line monitor: index 0 is the first negedge the line is low; bit i is sampled at i*CPB + CPB/2.
    initial begin
        logic [NB-1:0] bits;
        logic [DW-1:0] exp;
        forever begin
            @(negedge sysclk);
            if (mon_en && !rst && o_tx_serial === 1'b0) begin
                mon_busy = 1'b1;
                bits = '0;
                for (int i = 0; i < NB; i++) begin
                    repeat ((i == 0) ? CPB / 2 : CPB) @(negedge sysclk);
                    bits[i] = o_tx_serial;
                    if (i == NB - 1) check("done_early", {31'b0, o_tx_d}, 32'd0);
                end
                repeat (CPB - CPB / 2) @(negedge sysclk);
                check("done_pulse", {31'b0, o_tx_d}, 32'd1);
                check("done_line", {31'b0, o_tx_serial}, 32'd1);
                @(negedge sysclk);
                check("done_clear", {31'b0, o_tx_d}, 32'd0);
                check("gap_line", {31'b0, o_tx_serial}, 32'd1);
                if (sb.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("start_bit", {31'b0, bits[0]}, 32'd0);
                    check("data", {24'b0, bits[DW:1]}, {24'b0, exp});
`ifdef UART_TX_PARITY_EN
                    check("parity", {31'b0, bits[DW+1]}, {31'b0, ^exp});
`endif
                    check("stop_bit", {31'b0, bits[NB-1]}, 32'd1);
                    $display("frame: data=%02h expected=%02h", bits[DW:1], exp);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [DW-1:0] b, input bit push);
        @(negedge sysclk);
        check("pre_req_line", {31'b0, o_tx_serial}, 32'd1);
        i_tx = 1'b1;
        i_tx_byte = b;
        if (push) begin
            sb.push_back(b);
            frames++;
        end
        @(negedge sysclk);
        check("start_latency", {31'b0, o_tx_serial}, 32'd0);
        i_tx = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        check("drain_timeout", {31'b0, n < budget}, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        @(negedge sysclk);
        while (o_tx_d !== 1'b1 && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        check("done_timeout", {31'b0, n < budget}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge sysclk);
        check("reset_line", {31'b0, o_tx_serial}, 32'd1);
        check("reset_done", {31'b0, o_tx_d}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            check("idle_line", {31'b0, o_tx_serial}, 32'd1);
            check("idle_done", {31'b0, o_tx_d}, 32'd0);
        end

        send(8'b11001011, 1'b1);
        wait_idle(4000);

        // Byte changed mid-frame must not affect the frame in flight.
        send(8'hA5, 1'b1);
        repeat (3 * CPB) @(negedge sysclk);
        i_tx_byte = 8'h3C;
        wait_idle(4000);

        // Back-to-back with i_tx held high.
        @(negedge sysclk);
        i_tx = 1'b1;
        i_tx_byte = 8'h00;
        sb.push_back(8'h00);
        frames++;
        wait_done(4000);
        i_tx_byte = 8'hFF;
        sb.push_back(8'hFF);
        frames++;
        repeat (2) @(negedge sysclk);
        i_tx = 1'b0;
        wait_idle(4000);

        // Reset during data bit 3 of 8'h55 aborts the frame asynchronously.
        mon_en = 1'b0;
        send(8'h55, 1'b0);
        repeat (4 * CPB + CPB / 2) @(negedge sysclk);
        check("bit3_before_rst", {31'b0, o_tx_serial}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_async_line", {31'b0, o_tx_serial}, 32'd1);
        check("rst_async_done", {31'b0, o_tx_d}, 32'd0);
        repeat (3) @(negedge sysclk);
        check("rst_hold_line", {31'b0, o_tx_serial}, 32'd1);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge sysclk);
        check("post_rst_line", {31'b0, o_tx_serial}, 32'd1);
        send(8'h55, 1'b1);
        wait_idle(4000);

        for (int i = 0; i < 3; i++) begin
            send(DW'($urandom_range(0, 255)), 1'b1);
            wait_idle(4000);
        end

        repeat (4) @(negedge sysclk);
        check("done_count", done_cnt, frames);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
